i2c_reg_sequencer: RTL and testbench
====================================

I2C_REG_SEQUENCER -- requirements
Module: i2c_reg_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 65535, max cycles one controller command may wait for Ack (used only when the watchdog is compiled in).
REQ-002 clock  input  1  system clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 Start  input  1  single-cycle request to begin one register transaction.
REQ-005 Op  input  1  transaction type: 0 = register write, 1 = register read.
REQ-006 DevAddr  input  7  7-bit I2C slave address.
REQ-007 RegAddr  input  8  slave register index.
REQ-008 WrData  input  8  byte written on Op=0.
REQ-009 Busy  output  1  high from the cycle after accepted Start until the Done cycle inclusive.
REQ-010 Done  output  1  one-cycle completion pulse.
REQ-011 Nack  output  1  completion status, valid with Done and held until next Start: slave did not acknowledge.
REQ-012 Timeout  output  1  completion status, valid with Done and held until next Start: command watchdog expired.
REQ-013 RdData  output  8  byte returned by last successful read, held until next successful read.
REQ-014 I2C_Write  output  1  command-write strobe to the I2C controller.
REQ-015 I2C_Read  output  1  status/FIFO-read strobe to the I2C controller (dequeues one byte).
REQ-016 I2C_DataIn  output  13  command word: [12] RxN, [11] Rx, [10] Tx, [9] EnQ, [8] Clear, [7:0] data.
REQ-017 I2C_DataOut  input  11  controller status: [10] Nack, [9] FIFO full, [8] FIFO empty, [7:0] FIFO head byte.
REQ-018 I2C_Ack  input  1  controller completion of the current strobe.

Function
REQ-019 Start SHALL be accepted only in IDLE; Start while Busy SHALL be ignored with no effect on any output.
REQ-020 DevAddr, RegAddr, WrData and Op SHALL be registered on the accepting cycle; later input changes SHALL not affect the transaction.
REQ-021 Each command step SHALL drive exactly one strobe (I2C_Write or I2C_Read, never both) with exactly one command bit set in I2C_DataIn[12:8], held stable until the cycle I2C_Ack is sampled high.
REQ-022 After each sampled I2C_Ack the sequencer SHALL spend exactly one GAP cycle with both strobes low before the next step.
REQ-023 Write sequence: CLR (Clear) -> ENQ_DEV (EnQ {DevAddr,0}) -> ENQ_REG (EnQ RegAddr) -> ENQ_DATA (EnQ WrData) -> TX (Tx) -> STAT (Read) -> DONE.
REQ-024 Read sequence: CLR -> ENQ_DEV ({DevAddr,0}) -> ENQ_REG -> TX -> STAT -> CLR2 (Clear) -> ENQ_DEVR (EnQ {DevAddr,1}) -> RXN (RxN, data 8'd1) -> RX (Rx) -> RDDATA (Read) -> DONE.
REQ-025 In STAT, I2C_DataOut[10] sampled with I2C_Ack SHALL set Nack; on a read with Nack=1 the sequencer SHALL skip CLR2..RDDATA and go directly to DONE.
REQ-026 In RDDATA, with I2C_Ack: Nack = I2C_DataOut[10]; if Nack=0, RdData = I2C_DataOut[7:0]; if Nack=1, RdData unchanged.
REQ-027 DONE SHALL last one cycle asserting Done, then return to IDLE; Busy SHALL fall the cycle after Done.
REQ-028 Strobes SHALL be registered outputs; I2C_DataIn SHALL be 13'd0 whenever both strobes are low.
REQ-029 Start accepted in the same cycle Done is high SHALL be ignored (not in IDLE).

Reset
REQ-030 reset SHALL force IDLE, Busy=0, Done=0, Nack=0, Timeout=0, RdData=8'h00, both strobes 0, I2C_DataIn=0, watchdog count 0.
REQ-031 reset asserted mid-transaction SHALL abort it the next cycle without issuing Done; the first Start after reset SHALL begin with CLR.

Configuration
REQ-032 Macro I2C_SEQ_TIMEOUT_EN defined: a counter SHALL clear on each strobe assertion, count while a strobe waits for I2C_Ack, and on reaching TIMEOUT_CYCLES drop the strobe, set Timeout=1, Nack=0, and go to DONE.
REQ-033 Macro not defined: no counter logic SHALL exist, steps wait indefinitely for I2C_Ack, Timeout SHALL be tied 0.

Verification
REQ-034 Write, Dev=7'h50, Reg=8'h10, WrData=8'hA5, Ack 3 cycles after each strobe, status Nack=0 -> DataIn sequence 0x100,0x2A0,0x210,0x2A5,0x400, then Read; Done with Nack=0; RdData unchanged.
REQ-035 Read, Dev=7'h68, Reg=8'h75, RDDATA status 11'h068 -> commands 0x100,0x2D0,0x275,0x400, Read, 0x100,0x2D1,0x1001,0x800, Read; Done, RdData=8'h68, Nack=0.
REQ-036 Read with STAT status 11'h400 -> no CLR2..RX strobes; Done one GAP cycle after STAT Ack; Nack=1; RdData keeps prior value.
REQ-037 Start pulsed while Busy with different Op/addresses -> strobe sequence identical to uninterrupted run; exactly one Done.
REQ-038 Macro defined, TIMEOUT_CYCLES=16, I2C_Ack never returned on TX -> strobe drops after 16 wait cycles, Done with Timeout=1; macro undefined -> Busy stays high indefinitely; reset during TX -> IDLE next cycle, strobes 0, no Done.

Source files
------------

// File: rtl/i2c_reg_sequencer.sv
// Sequences I2C controller commands for one register write or read.
// Define I2C_SEQ_TIMEOUT_EN to build in the per-command Ack watchdog.
module i2c_reg_sequencer #(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        Start,
  input  logic        Op,
  input  logic [6:0]  DevAddr,
  input  logic [7:0]  RegAddr,
  input  logic [7:0]  WrData,
  output logic        Busy,
  output logic        Done,
  output logic        Nack,
  output logic        Timeout,
  output logic [7:0]  RdData,
  output logic        I2C_Write,
  output logic        I2C_Read,
  output logic [12:0] I2C_DataIn,
  input  logic [10:0] I2C_DataOut,
  input  logic        I2C_Ack
);

  typedef enum logic [1:0] {
    S_IDLE, S_WAIT, S_GAP, S_DONE
  } state_e;

  typedef enum logic [3:0] {
    P_CLR, P_DEV, P_REG, P_DATA, P_TX, P_STAT,
    P_CLR2, P_DEVR, P_RXN, P_RX, P_RDD, P_FIN
  } step_e;

  state_e      state_q;
  step_e       step_q;
  step_e       nxt_d;
  step_e       iss_step;
  logic        op_q;
  logic [6:0]  dev_q;
  logic [7:0]  reg_q;
  logic [7:0]  wd_q;
  logic        busy_q;
  logic        done_q;
  logic        nack_q;
  logic [7:0]  rd_q;
  logic        wr_q;
  logic        rds_q;
  logic [12:0] din_q;
  logic        iss_wr_d;
  logic        iss_rd_d;
  logic [12:0] iss_din_d;
  logic        wd_hit;
  logic        unused_ok;

  assign unused_ok = ^{I2C_DataOut[9:8], TIMEOUT_CYCLES == 0};

  always_comb begin
    nxt_d = P_FIN;
    case (step_q)
      P_CLR:   nxt_d = P_DEV;
      P_DEV:   nxt_d = P_REG;
      P_REG:   nxt_d = op_q ? P_TX : P_DATA;
      P_DATA:  nxt_d = P_TX;
      P_TX:    nxt_d = P_STAT;
      P_STAT:  nxt_d = (op_q && !I2C_DataOut[10]) ? P_CLR2 : P_FIN;
      P_CLR2:  nxt_d = P_DEVR;
      P_DEVR:  nxt_d = P_RXN;
      P_RXN:   nxt_d = P_RX;
      P_RX:    nxt_d = P_RDD;
      default: nxt_d = P_FIN;
    endcase
  end

  // Status reads carry no command bits, so their data word stays zero.
  always_comb begin
    iss_step  = (state_q == S_IDLE) ? P_CLR : step_q;
    iss_wr_d  = 1'b1;
    iss_rd_d  = 1'b0;
    iss_din_d = '0;
    case (iss_step)
      P_CLR, P_CLR2: iss_din_d = 13'h100;
      P_DEV:         iss_din_d = {5'b00010, dev_q, 1'b0};
      P_DEVR:        iss_din_d = {5'b00010, dev_q, 1'b1};
      P_REG:         iss_din_d = {5'b00010, reg_q};
      P_DATA:        iss_din_d = {5'b00010, wd_q};
      P_TX:          iss_din_d = 13'h400;
      P_RXN:         iss_din_d = 13'h1001;
      P_RX:          iss_din_d = 13'h800;
      default: begin
        iss_wr_d = 1'b0;
        iss_rd_d = 1'b1;
      end
    endcase
  end

`ifdef I2C_SEQ_TIMEOUT_EN
  logic [31:0] wd_cnt_q;
  logic        tmo_q;
  logic        issue;

  assign issue  = (state_q == S_IDLE && Start) ||
                  (state_q == S_GAP && step_q != P_FIN);
  assign wd_hit = (state_q == S_WAIT) && !I2C_Ack &&
                  (wd_cnt_q == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      wd_cnt_q <= '0;
      tmo_q    <= 1'b0;
    end else begin
      if (issue)
        wd_cnt_q <= '0;
      else if (state_q == S_WAIT && !I2C_Ack)
        wd_cnt_q <= wd_cnt_q + 32'd1;
      if (state_q == S_IDLE && Start)
        tmo_q <= 1'b0;
      else if (wd_hit)
        tmo_q <= 1'b1;
    end
  end

  assign Timeout = tmo_q;
`else
  assign wd_hit  = 1'b0;
  assign Timeout = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      step_q  <= P_CLR;
      op_q    <= 1'b0;
      dev_q   <= '0;
      reg_q   <= '0;
      wd_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      nack_q  <= 1'b0;
      rd_q    <= '0;
      wr_q    <= 1'b0;
      rds_q   <= 1'b0;
      din_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (Start) begin
            op_q    <= Op;
            dev_q   <= DevAddr;
            reg_q   <= RegAddr;
            wd_q    <= WrData;
            busy_q  <= 1'b1;
            nack_q  <= 1'b0;
            step_q  <= P_CLR;
            wr_q    <= iss_wr_d;
            rds_q   <= iss_rd_d;
            din_q   <= iss_din_d;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (I2C_Ack) begin
            wr_q    <= 1'b0;
            rds_q   <= 1'b0;
            din_q   <= '0;
            step_q  <= nxt_d;
            state_q <= S_GAP;
            if (step_q == P_STAT)
              nack_q <= I2C_DataOut[10];
            if (step_q == P_RDD) begin
              nack_q <= I2C_DataOut[10];
              if (!I2C_DataOut[10])
                rd_q <= I2C_DataOut[7:0];
            end
          end else if (wd_hit) begin
            wr_q    <= 1'b0;
            rds_q   <= 1'b0;
            din_q   <= '0;
            nack_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_GAP: begin
          if (step_q == P_FIN) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            wr_q    <= iss_wr_d;
            rds_q   <= iss_rd_d;
            din_q   <= iss_din_d;
            state_q <= S_WAIT;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign Busy       = busy_q;
  assign Done       = done_q;
  assign Nack       = nack_q;
  assign RdData     = rd_q;
  assign I2C_Write  = wr_q;
  assign I2C_Read   = rds_q;
  assign I2C_DataIn = din_q;

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Scoreboard bench for i2c_reg_sequencer: directed write/read transactions
// against a simple controller responder; honours I2C_SEQ_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_i2c_reg_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        Start;
  logic        Op;
  logic [6:0]  DevAddr;
  logic [7:0]  RegAddr;
  logic [7:0]  WrData;
  logic        Busy;
  logic        Done;
  logic        Nack;
  logic        Timeout;
  logic [7:0]  RdData;
  logic        I2C_Write;
  logic        I2C_Read;
  logic [12:0] I2C_DataIn;
  logic [10:0] I2C_DataOut;
  logic        I2C_Ack;

  i2c_reg_sequencer #(.TIMEOUT_CYCLES(16)) dut (
    .clock       (clock),
    .reset       (reset),
    .Start       (Start),
    .Op          (Op),
    .DevAddr     (DevAddr),
    .RegAddr     (RegAddr),
    .WrData      (WrData),
    .Busy        (Busy),
    .Done        (Done),
    .Nack        (Nack),
    .Timeout     (Timeout),
    .RdData      (RdData),
    .I2C_Write   (I2C_Write),
    .I2C_Read    (I2C_Read),
    .I2C_DataIn  (I2C_DataIn),
    .I2C_DataOut (I2C_DataOut),
    .I2C_Ack     (I2C_Ack)
  );

  always #5 clock = ~clock;

`ifdef I2C_SEQ_TIMEOUT_EN
  localparam int HANG = 8;
`else
  localparam int HANG = 200;
`endif

  int checks = 0;
  int errors = 0;
  logic [14:0] exp_cmd_q[$];
  logic [9:0]  exp_done_q[$];
  logic        hold_tx = 1'b0;
  logic [10:0] stat_resp = '0;
  logic [10:0] rdd_resp = '0;
  int          rd_idx = 0;
  int          cyc = 0;
  int          rd_ack_cyc = 0;
  int          last_hi = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_w(input logic [12:0] din);
    exp_cmd_q.push_back({1'b1, 1'b0, din});
  endtask

  task automatic exp_r();
    exp_cmd_q.push_back({1'b0, 1'b1, 13'h0});
  endtask

  task automatic exp_done(input logic n, input logic t, input logic [7:0] rd);
    exp_done_q.push_back({n, t, rd});
  endtask

  initial forever begin
    @(posedge clock);
    cyc = cyc + 1;
  end

  // Controller model: Ack three cycles after a strobe rises.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    I2C_Ack = 1'b0;
    I2C_DataOut = '0;
    forever begin
      @(negedge clock);
      I2C_Ack = 1'b0;
      if ((I2C_Write === 1'b1 || I2C_Read === 1'b1) &&
          !(hold_tx && I2C_DataIn == 13'h400)) begin
        wait_cnt++;
        if (wait_cnt == 3) begin
          I2C_Ack = 1'b1;
          wait_cnt = 0;
          if (I2C_Read) begin
            I2C_DataOut = (rd_idx == 0) ? stat_resp : rdd_resp;
            rd_idx++;
            rd_ack_cyc = cyc;
          end
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  initial begin
    logic        prev;
    logic        stb;
    int          low_run;
    int          hi_run;
    bit          seen;
    logic [14:0] e;
    logic [9:0]  d;
    prev = 1'b0;
    low_run = 0;
    hi_run = 0;
    seen = 1'b0;
    repeat (2) @(negedge clock);
    forever begin
      @(negedge clock);
      stb = I2C_Write | I2C_Read;
      if (stb) begin
        chk("strobe_excl", {31'd0, I2C_Write & I2C_Read}, 32'd0);
      end else begin
        chk("datain_idle", {19'd0, I2C_DataIn}, 32'd0);
      end
      if (stb && !prev) begin
        chk("step_gap", low_run, seen ? 32'd1 : 32'd0);
        if (exp_cmd_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_cmd: got %0h expected none",
                   {I2C_Write, I2C_Read, I2C_DataIn});
        end else begin
          e = exp_cmd_q.pop_front();
          chk("cmd", {17'd0, I2C_Write, I2C_Read, I2C_DataIn}, {17'd0, e});
        end
        seen = 1'b1;
        hi_run = 0;
      end
      if (stb) hi_run++;
      else if (prev) last_hi = hi_run;
      if (stb) low_run = 0;
      else if (Busy) low_run++;
      if (!Busy) begin
        seen = 1'b0;
        low_run = 0;
      end
      if (Done) begin
        chk("busy_at_done", {31'd0, Busy}, 32'd1);
        if (exp_done_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got Nack=%0b Timeout=%0b RdData=%0h expected none",
                   Nack, Timeout, RdData);
        end else begin
          d = exp_done_q.pop_front();
          chk("done_status", {22'd0, Nack, Timeout, RdData}, {22'd0, d});
        end
      end
      prev = stb;
    end
  end

  task automatic start_txn(input logic op, input logic [6:0] dev,
                           input logic [7:0] ra, input logic [7:0] wd);
    @(negedge clock);
    Op = op;
    DevAddr = dev;
    RegAddr = ra;
    WrData = wd;
    Start = 1'b1;
    rd_idx = 0;
    @(negedge clock);
    Start = 1'b0;
    Op = ~op;
    DevAddr = ~dev;
    RegAddr = ~ra;
    WrData = ~wd;
  endtask

  task automatic wait_done(input int limit, input string name);
    int n;
    n = 0;
    while (Done !== 1'b1 && n < limit) begin
      @(negedge clock);
      n++;
    end
    if (Done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s: Done=%b expected 1 within %0d cycles", name, Done, limit);
    end
  endtask

  task automatic finish_txn(input bit pulse);
    chk("stat_to_done", cyc - rd_ack_cyc, 32'd2);
    if (pulse) begin
      Start = 1'b1;
      Op = 1'b1;
      DevAddr = 7'h68;
      RegAddr = 8'h75;
    end
    @(negedge clock);
    Start = 1'b0;
    chk("busy_fall", {31'd0, Busy}, 32'd0);
    chk("queue_drained", exp_cmd_q.size(), 32'd0);
  endtask

  task automatic chk_reset_state(input string name);
    chk(name, {18'd0, Busy, Done, Nack, Timeout, I2C_Write, I2C_Read,
               I2C_DataIn[7:0]}, 32'd0);
    chk({name, "_din"}, {19'd0, I2C_DataIn}, 32'd0);
    chk({name, "_rd"}, {24'd0, RdData}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running expected finish");
    $fatal(1, "global timeout");
  end

  initial begin
    reset = 1'b1;
    Start = 1'b0;
    Op = 1'b0;
    DevAddr = '0;
    RegAddr = '0;
    WrData = '0;
    repeat (3) @(negedge clock);
    chk_reset_state("reset_state");
    reset = 1'b0;

    // Register write
    stat_resp = 11'h000;
    exp_w(13'h100); exp_w(13'h2A0); exp_w(13'h210);
    exp_w(13'h2A5); exp_w(13'h400); exp_r();
    exp_done(1'b0, 1'b0, 8'h00);
    start_txn(1'b0, 7'h50, 8'h10, 8'hA5);
    wait_done(200, "write_done");
    finish_txn(1'b0);

    // Register read
    stat_resp = 11'h000;
    rdd_resp = 11'h068;
    exp_w(13'h100); exp_w(13'h2D0); exp_w(13'h275); exp_w(13'h400); exp_r();
    exp_w(13'h100); exp_w(13'h2D1); exp_w(13'h1001); exp_w(13'h800); exp_r();
    exp_done(1'b0, 1'b0, 8'h68);
    start_txn(1'b1, 7'h68, 8'h75, 8'h00);
    wait_done(300, "read_done");
    finish_txn(1'b0);

    // Read that is not acknowledged at the status step
    stat_resp = 11'h400;
    exp_w(13'h100); exp_w(13'h242); exp_w(13'h233); exp_w(13'h400); exp_r();
    exp_done(1'b1, 1'b0, 8'h68);
    start_txn(1'b1, 7'h21, 8'h33, 8'h00);
    wait_done(200, "read_nack_done");
    finish_txn(1'b0);

    // Start while busy, then Start during the Done cycle
    stat_resp = 11'h000;
    exp_w(13'h100); exp_w(13'h2A0); exp_w(13'h210);
    exp_w(13'h23C); exp_w(13'h400); exp_r();
    exp_done(1'b0, 1'b0, 8'h68);
    start_txn(1'b0, 7'h50, 8'h10, 8'h3C);
    repeat (7) @(negedge clock);
    Start = 1'b1;
    Op = 1'b1;
    DevAddr = 7'h11;
    RegAddr = 8'h22;
    WrData = 8'h33;
    @(negedge clock);
    Start = 1'b0;
    wait_done(200, "busy_start_done");
    finish_txn(1'b1);
    repeat (10) @(negedge clock);
    chk("done_start_ignored", {31'd0, Busy}, 32'd0);

    // Controller never acknowledges the transmit step
    hold_tx = 1'b1;
`ifdef I2C_SEQ_TIMEOUT_EN
    exp_w(13'h100); exp_w(13'h254); exp_w(13'h201); exp_w(13'h202); exp_w(13'h400);
    exp_done(1'b0, 1'b1, 8'h68);
    start_txn(1'b0, 7'h2A, 8'h01, 8'h02);
    wait_done(300, "timeout_done");
    @(negedge clock);
    chk("timeout_busy_fall", {31'd0, Busy}, 32'd0);
    chk("timeout_hi_cycles", last_hi, 32'd16);
    chk("timeout_drained", exp_cmd_q.size(), 32'd0);
`endif
    exp_w(13'h100); exp_w(13'h254); exp_w(13'h201); exp_w(13'h202); exp_w(13'h400);
    start_txn(1'b0, 7'h2A, 8'h01, 8'h02);
    begin
      int n;
      n = 0;
      while (I2C_DataIn !== 13'h400 && n < 200) begin
        @(negedge clock);
        n++;
      end
      chk("tx_reached", {19'd0, I2C_DataIn}, 32'h400);
    end
    repeat (HANG) @(negedge clock);
    chk("hang_busy", {31'd0, Busy}, 32'd1);
    chk("hang_tx_held", {18'd0, I2C_Write, I2C_DataIn}, {18'd0, 1'b1, 13'h400});
    reset = 1'b1;
    @(negedge clock);
    chk_reset_state("abort_reset");
    reset = 1'b0;
    hold_tx = 1'b0;
    chk("abort_drained", exp_cmd_q.size(), 32'd0);

    // First transaction after reset starts from the clear step
    stat_resp = 11'h000;
    rdd_resp = 11'h0A5;
    exp_w(13'h100); exp_w(13'h21E); exp_w(13'h2FF); exp_w(13'h400); exp_r();
    exp_w(13'h100); exp_w(13'h21F); exp_w(13'h1001); exp_w(13'h800); exp_r();
    exp_done(1'b0, 1'b0, 8'hA5);
    start_txn(1'b1, 7'h0F, 8'hFF, 8'h00);
    wait_done(300, "post_reset_read_done");
    finish_txn(1'b0);

    // Read whose data fetch reports Nack keeps the previous byte
    stat_resp = 11'h000;
    rdd_resp = 11'h4CC;
    exp_w(13'h100); exp_w(13'h266); exp_w(13'h244); exp_w(13'h400); exp_r();
    exp_w(13'h100); exp_w(13'h267); exp_w(13'h1001); exp_w(13'h800); exp_r();
    exp_done(1'b1, 1'b0, 8'hA5);
    start_txn(1'b1, 7'h33, 8'h44, 8'h00);
    wait_done(300, "rdd_nack_done");
    finish_txn(1'b0);

    repeat (5) @(negedge clock);
    chk("done_queue_drained", exp_done_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
